// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial add controller. A single 1-bit full-adder cell is time-shared
// across a WIDTH-bit addition: operands are latched on an accepted start and
// walked LSB-first through the adder, one bit per clock, with the carry held
// in a register between bits. Start-to-done latency is WIDTH+1 clocks and
// back-to-back throughput is one operation every WIDTH+2 clocks.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a sub_i port is added. With sub_i=1 on an accepted start,
//   B is loaded inverted and the carry is forced to 1, so the result is
//   a-b mod 2^WIDTH and c_out_o=1 means "no borrow" (a >= b).
//   When undefined, the block is add-only and has no inversion logic.
//
// Parameters:
//   WIDTH    operand/result width in bits (legal range 2..32)
//
// Ports:
//   clk_i    in   1      clock, all state updates on rising edge
//   rst_n_i  in   1      asynchronous active-low reset
//   start_i  in   1      operation request, sampled only in IDLE
//   a_i      in   WIDTH  operand A, sampled on accepted start
//   b_i      in   WIDTH  operand B, sampled on accepted start
//   c_in_i   in   1      carry-in, sampled on accepted start
//   sub_i    in   1      subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy_o   out  1      high while the bit loop runs
//   done_o   out  1      one-cycle pulse, result valid
//   sum_o    out  WIDTH  result of the last completed operation
//   c_out_o  out  1      carry-out of the last completed operation
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] r_next;

    // Operand conditioning at accept time. In subtract mode the two's
    // complement of B is formed by inverting it and injecting a carry of 1,
    // so the same adder cell serves both operations.
    always_comb begin
        b_load     = b_i;
        carry_load = c_in_i;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub_i) begin
            b_load     = ~b_i;
            carry_load = 1'b1;
        end
`endif
    end

    // The shared 1-bit full adder, always looking at the current LSBs and
    // the registered carry.
    always_comb begin
        fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
        fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    // Result shift register advances right with the new sum bit entering at
    // the MSB; after WIDTH shifts the first (LSB) sum bit has reached bit 0.
    always_comb begin
        r_next = {fa_sum, r_q[WIDTH-1:1]};
    end

    // Controller FSM with registered outputs. The last RUN cycle publishes
    // the final shifted value directly into sum_o/c_out_o so the result is
    // already visible during the DONE cycle together with done_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            sum_o   <= '0;
            c_out_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    r_q     <= r_next;
                    carry_q <= fa_carry;
                    if (cnt_q == CNT_LAST) begin
                        // Counter parks at its last value instead of
                        // wrapping; it is reloaded on the next accept.
                        sum_o   <= r_next;
                        c_out_o <= fa_carry;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    // start_i is deliberately ignored here; the earliest
                    // next accept is the following IDLE cycle.
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results come
// from plain integer arithmetic on the operands; the handshake timing is
// checked against the fixed WIDTH+1 latency and WIDTH+2 accept spacing.
// Subtract tests are included only when SERIAL_ADDER_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int assertions;
    int failures;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .c_in_i  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .c_out_o (c_out)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: add gives (a+b+cin) with bit W as carry; subtract gives
    // a-b mod 2^W and carry means a >= b.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
        int unsigned total;
        logic [W:0]  res;
        if (msub) begin
            total    = (int'(ma) - int'(mb)) & ((1 << W) - 1);
            res      = (W+1)'(total);
            res[W]   = (ma >= mb);
        end else begin
            total = int'(ma) + int'(mb) + int'(mcin);
            res   = (W+1)'(total);
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        sub   = 1'b0;
        #12;
        assertions++;
        if ({busy, done, sum, c_out} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, c_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // One full operation with per-cycle handshake checks. Called just after
    // a clock edge with the DUT idle.
    task automatic test_single(input string name, input logic [W-1:0] ta,
                               input logic [W-1:0] tb, input logic tcin, input logic tsub);
        logic [W:0] exp;
        exp   = model(ta, tb, tcin, tsub);
        start = 1'b1;
        a     = ta;
        b     = tb;
        c_in  = tcin;
        sub   = tsub;
        tick();
        // Operands may change freely after acceptance.
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        c_in  = 1'($urandom);
        sub   = 1'b0;
        for (int i = 0; i < W; i++) begin
            assertions++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s_run%0d: got busy=%b done=%b, want busy=1 done=0",
                         name, i, busy, done);
            end
            tick();
        end
        assertions++;
        if (done !== 1'b1 || busy !== 1'b0 || sum !== exp[W-1:0] || c_out !== exp[W]) begin
            failures++;
            $display("[TB] FAIL %s_done: got done=%b busy=%b sum=%h cout=%b, want done=1 busy=0 sum=%h cout=%b",
                     name, done, busy, sum, c_out, exp[W-1:0], exp[W]);
        end
        tick();
        assertions++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== exp[W-1:0] || c_out !== exp[W]) begin
            failures++;
            $display("[TB] FAIL %s_hold: got done=%b busy=%b sum=%h cout=%b, want done=0 busy=0 sum=%h cout=%b",
                     name, done, busy, sum, c_out, exp[W-1:0], exp[W]);
        end
    endtask

    task automatic test_directed();
        test_single("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        test_single("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        test_single("add_00_00_cin", 8'h00, 8'h00, 1'b1, 1'b0);
        test_single("add_ff_ff_cin", 8'hFF, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            test_single($sformatf("rand%0d", n), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    // start held high with operands changing every cycle: accepts must land
    // every W+2 edges and use only the operands present at each accept.
    task automatic test_back_to_back();
        logic [W:0] exp;
        int         period;
        period = W + 2;
        exp    = '0;
        start  = 1'b1;
        for (int t = 0; t < 4 * period; t++) begin
            a    = W'($urandom);
            b    = W'($urandom);
            c_in = 1'($urandom);
            if (t % period == 0) exp = model(a, b, c_in, 1'b0);
            tick();
            assertions++;
            if (t % period == W) begin
                if (done !== 1'b1 || busy !== 1'b0 || sum !== exp[W-1:0] || c_out !== exp[W]) begin
                    failures++;
                    $display("[TB] FAIL b2b_done_t%0d: got done=%b busy=%b sum=%h cout=%b, want done=1 busy=0 sum=%h cout=%b",
                             t, done, busy, sum, c_out, exp[W-1:0], exp[W]);
                end
            end else begin
                if (done !== 1'b0 || busy !== (t % period < W)) begin
                    failures++;
                    $display("[TB] FAIL b2b_hs_t%0d: got done=%b busy=%b, want done=0 busy=%b",
                             t, done, busy, (t % period < W));
                end
            end
        end
        start = 1'b0;
    endtask

    // Asynchronous reset in the middle of a run discards the operation.
    task automatic test_reset_mid_run();
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h3C;
        c_in  = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        assertions++;
        if ({busy, done, sum, c_out} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, c_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < W + 2; i++) begin
            assertions++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL post_reset_idle%0d: got done=%b busy=%b, want 0 0", i, done, busy);
            end
            tick();
        end
        test_single("after_reset_01_02", 8'h01, 8'h02, 1'b0, 1'b0);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_subtract();
        test_single("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
        test_single("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1);
        for (int n = 0; n < 10; n++) begin
            test_single($sformatf("sub_rand%0d", n), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
    endtask
`endif

    initial begin
        assertions = 0;
        failures   = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_subtract();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
